// File: rtl/map_pkg.sv
// Shared types and sizing for the map layer buffer: row payload struct and FSM states.
package map_pkg;

    localparam int MAP_WIDTH       = 7;
    localparam int MAP_DEPTH       = 8;
    localparam int MAP_GEN_LATENCY = 2;
    localparam int ROW_AW          = $clog2(MAP_DEPTH);
    localparam int COL_AW          = $clog2(MAP_WIDTH);
    localparam int VR_W            = ROW_AW + 1;

    // Index 0 is the leftmost cell, matching the generator's [0:WIDTH-1] planes.
    typedef logic [0:MAP_WIDTH-1] cells_t;

    typedef struct packed {
        cells_t layer;
        cells_t btype;
        cells_t bonus;
    } row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REQ,
        S_INIT_FILL,
        S_READY,
        S_SCROLL_REQ,
        S_SCROLL_WAIT,
        S_SCROLL_DONE
    } state_t;

    function automatic logic row_in_range(input logic [ROW_AW-1:0] r);
        return int'(r) < MAP_DEPTH;
    endfunction

    function automatic logic col_in_range(input logic [COL_AW-1:0] c);
        return int'(c) < MAP_WIDTH;
    endfunction

endpackage

// File: rtl/map_row_store.sv
// Scrolling row store: shift-in at row 0, clear-all, single bonus-bit clear, registered read.
// Bonus-bit clearing exists only when MAP_LAYER_BUFFER_BONUS_EN is defined.
module map_row_store
    import map_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shift_i,
    input  row_t              in_row_i,
    input  logic              bonus_clr_i,
    input  logic [ROW_AW-1:0] bonus_row_i,
    input  logic [COL_AW-1:0] bonus_col_i,
    input  logic [ROW_AW-1:0] rd_row_i,
    output row_t              rd_data_o
);

    row_t rows_q  [MAP_DEPTH];
    row_t cleared [MAP_DEPTH];
    row_t rd_q;

    // The collected-bonus clear is applied before the shift so the cleared cell travels with its row.
    always_comb begin
        for (int i = 0; i < MAP_DEPTH; i++) begin
            cleared[i] = rows_q[i];
        end
`ifdef MAP_LAYER_BUFFER_BONUS_EN
        if (bonus_clr_i && row_in_range(bonus_row_i) && col_in_range(bonus_col_i)) begin
            cleared[bonus_row_i].bonus[bonus_col_i] = 1'b0;
        end
`endif
    end

`ifndef MAP_LAYER_BUFFER_BONUS_EN
    logic unused_clr;
    assign unused_clr = ^{bonus_clr_i, bonus_row_i, bonus_col_i};
`endif

    for (genvar gi = 0; gi < MAP_DEPTH; gi++) begin : g_row
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rows_q[gi] <= '0;
            end else if (clear_i) begin
                rows_q[gi] <= '0;
            end else if (shift_i) begin
                if (gi == 0) begin
                    rows_q[gi] <= in_row_i;
                end else begin
                    rows_q[gi] <= cleared[gi-1];
                end
            end else begin
                rows_q[gi] <= cleared[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= row_in_range(rd_row_i) ? rows_q[rd_row_i] : '0;
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/map_layer_buffer.sv
// Generator-facing map buffer: request/capture FSM, generator latency counter, fill count.
// Define MAP_LAYER_BUFFER_BONUS_EN to store the bonus plane and enable bonus_clr_i.
module map_layer_buffer
    import map_pkg::*;
#(
    parameter int GEN_LATENCY = MAP_GEN_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              scroll_req_i,
    output logic              generate_map_o,
    input  cells_t            layer_map_i,
    input  cells_t            block_type_i,
    input  cells_t            bonus_map_i,
    input  logic              load_layer_i,
    input  logic              map_ready_i,
    input  logic [ROW_AW-1:0] rd_row_i,
    output cells_t            rd_layer_o,
    output cells_t            rd_type_o,
    output cells_t            rd_bonus_o,
    input  logic              bonus_clr_i,
    input  logic [ROW_AW-1:0] bonus_row_i,
    input  logic [COL_AW-1:0] bonus_col_i,
    output logic              busy_o,
    output logic              scroll_done_o,
    output logic [VR_W-1:0]   valid_rows_o
);

    localparam int              LAT_W    = (GEN_LATENCY > 1) ? $clog2(GEN_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(GEN_LATENCY - 1);
    localparam logic [VR_W-1:0]  VR_FULL  = VR_W'(MAP_DEPTH);

    state_t            state_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [VR_W-1:0]   valid_rows_q;
    logic              generate_map_q;
    logic              scroll_done_q;
    logic              busy_q;

    logic              shift_en;
    row_t              in_row;
    row_t              rd_data;

    // Init rows arrive on load strobes; a scroll row is taken blind once the latency elapses.
    assign shift_en = !start_i &&
                      ((state_q == S_INIT_FILL && load_layer_i) ||
                       (state_q == S_SCROLL_WAIT && lat_cnt_q == LAT_LAST));

    assign in_row.layer = layer_map_i;
    assign in_row.btype = block_type_i;
`ifdef MAP_LAYER_BUFFER_BONUS_EN
    assign in_row.bonus = bonus_map_i;
    assign rd_bonus_o   = rd_data.bonus;
`else
    assign in_row.bonus = '0;
    assign rd_bonus_o   = '0;
    logic unused_bonus;
    assign unused_bonus = ^{bonus_map_i, rd_data.bonus};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            lat_cnt_q      <= '0;
            valid_rows_q   <= '0;
            generate_map_q <= 1'b0;
            scroll_done_q  <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            generate_map_q <= 1'b0;
            scroll_done_q  <= 1'b0;
            if (start_i) begin
                state_q        <= S_INIT_REQ;
                generate_map_q <= 1'b1;
                busy_q         <= 1'b1;
                valid_rows_q   <= '0;
                lat_cnt_q      <= '0;
            end else begin
                if (shift_en && valid_rows_q != VR_FULL) begin
                    valid_rows_q <= valid_rows_q + VR_W'(1);
                end
                case (state_q)
                    S_IDLE: ;
                    S_INIT_REQ: state_q <= S_INIT_FILL;
                    S_INIT_FILL: begin
                        if (map_ready_i) begin
                            state_q <= S_READY;
                            busy_q  <= 1'b0;
                        end
                    end
                    S_READY: begin
                        if (scroll_req_i) begin
                            state_q        <= S_SCROLL_REQ;
                            generate_map_q <= 1'b1;
                            busy_q         <= 1'b1;
                        end
                    end
                    S_SCROLL_REQ: begin
                        state_q   <= S_SCROLL_WAIT;
                        lat_cnt_q <= '0;
                    end
                    S_SCROLL_WAIT: begin
                        if (lat_cnt_q == LAT_LAST) begin
                            state_q       <= S_SCROLL_DONE;
                            scroll_done_q <= 1'b1;
                        end else begin
                            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                        end
                    end
                    S_SCROLL_DONE: begin
                        state_q <= S_READY;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    map_row_store u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_i),
        .shift_i     (shift_en),
        .in_row_i    (in_row),
        .bonus_clr_i (bonus_clr_i),
        .bonus_row_i (bonus_row_i),
        .bonus_col_i (bonus_col_i),
        .rd_row_i    (rd_row_i),
        .rd_data_o   (rd_data)
    );

    assign generate_map_o = generate_map_q;
    assign scroll_done_o  = scroll_done_q;
    assign busy_o         = busy_q;
    assign valid_rows_o   = valid_rows_q;
    assign rd_layer_o     = rd_data.layer;
    assign rd_type_o      = rd_data.btype;

endmodule

// File: tb/tb_map_layer_buffer.sv
// Directed self-checking bench for map_layer_buffer (default and MAP_LAYER_BUFFER_BONUS_EN builds).
module tb_map_layer_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, scroll_req_i, load_layer_i, map_ready_i, bonus_clr_i;
    logic [0:6]  layer_map_i, block_type_i, bonus_map_i;
    logic [2:0]  rd_row_i, bonus_row_i, bonus_col_i;
    logic        generate_map_o, busy_o, scroll_done_o;
    logic [0:6]  rd_layer_o, rd_type_o, rd_bonus_o;
    logic [3:0]  valid_rows_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    map_layer_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .scroll_req_i   (scroll_req_i),
        .generate_map_o (generate_map_o),
        .layer_map_i    (layer_map_i),
        .block_type_i   (block_type_i),
        .bonus_map_i    (bonus_map_i),
        .load_layer_i   (load_layer_i),
        .map_ready_i    (map_ready_i),
        .rd_row_i       (rd_row_i),
        .rd_layer_o     (rd_layer_o),
        .rd_type_o      (rd_type_o),
        .rd_bonus_o     (rd_bonus_o),
        .bonus_clr_i    (bonus_clr_i),
        .bonus_row_i    (bonus_row_i),
        .bonus_col_i    (bonus_col_i),
        .busy_o         (busy_o),
        .scroll_done_o  (scroll_done_o),
        .valid_rows_o   (valid_rows_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:6] bexp(input logic [0:6] v);
`ifdef MAP_LAYER_BUFFER_BONUS_EN
        return v;
`else
        return 7'b0;
`endif
    endfunction

    task automatic chk_row(input string tag, input int r,
                           input logic [0:6] el, input logic [0:6] et, input logic [0:6] eb);
        rd_row_i = 3'(r);
        tick();
        chk($sformatf("%s_layer_r%0d", tag, r), 32'(rd_layer_o), 32'(el));
        chk($sformatf("%s_type_r%0d", tag, r), 32'(rd_type_o), 32'(et));
        chk($sformatf("%s_bonus_r%0d", tag, r), 32'(rd_bonus_o), 32'(bexp(eb)));
        $display("read %s row%0d layer=%b type=%b bonus=%b", tag, r, rd_layer_o, rd_type_o, rd_bonus_o);
    endtask

    logic [0:6] fill_l [4];
    logic [0:6] fill_t [4];
    logic [0:6] fill_b [4];

    initial begin
        int n;
        fill_l = '{7'b0001000, 7'b1010101, 7'b0101010, 7'b1010101};
        fill_t = '{7'b1100000, 7'b0110000, 7'b0011000, 7'b0001100};
        fill_b = '{7'b0000100, 7'b0010000, 7'b0100000, 7'b0000000};

        rst_n = 1'b0; start_i = 0; scroll_req_i = 0; load_layer_i = 0; map_ready_i = 0;
        bonus_clr_i = 0; layer_map_i = '0; block_type_i = '0; bonus_map_i = '0;
        rd_row_i = '0; bonus_row_i = '0; bonus_col_i = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_genmap", 32'(generate_map_o), 32'd0);
        chk("rst_done", 32'(scroll_done_o), 32'd0);
        chk("rst_valid", 32'(valid_rows_o), 32'd0);
        chk("rst_rd", 32'(rd_layer_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Initial fill, with a stray scroll request during the fill phase
        start_i = 1; tick(); start_i = 0;
        chk("init_genmap", 32'(generate_map_o), 32'd1);
        chk("init_busy", 32'(busy_o), 32'd1);
        tick();
        chk("fill_genmap_low", 32'(generate_map_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            layer_map_i = fill_l[k]; block_type_i = fill_t[k]; bonus_map_i = fill_b[k];
            load_layer_i = 1; map_ready_i = (k == 3); scroll_req_i = (k == 1);
            tick();
            chk($sformatf("fill%0d_genmap", k), 32'(generate_map_o), 32'd0);
            $display("load %0d layer=%b valid_rows=%0d", k, fill_l[k], valid_rows_o);
        end
        load_layer_i = 0; map_ready_i = 0; scroll_req_i = 0;
        layer_map_i = 7'b1111111; block_type_i = 7'b1111111; bonus_map_i = 7'b1111111;
        chk("fill_valid", 32'(valid_rows_o), 32'd4);
        chk("fill_busy", 32'(busy_o), 32'd0);
        tick();
        chk("fill_no_extra_req", 32'(generate_map_o), 32'd0);
        chk("fill_valid_hold", 32'(valid_rows_o), 32'd4);
        chk_row("fill", 0, 7'b1010101, 7'b0001100, 7'b0000000);
        chk_row("fill", 1, 7'b0101010, 7'b0011000, 7'b0100000);
        chk_row("fill", 2, 7'b1010101, 7'b0110000, 7'b0010000);
        chk_row("fill", 3, 7'b0001000, 7'b1100000, 7'b0000100);
        chk_row("fill", 4, 7'b0000000, 7'b0000000, 7'b0000000);

        // Bonus clear of row2 col2 while idle in ready
        bonus_clr_i = 1; bonus_row_i = 3'd2; bonus_col_i = 3'd2;
        tick();
        bonus_clr_i = 0;
        chk_row("bclr", 2, 7'b1010101, 7'b0110000, 7'b0000000);

        // First scroll: latency exact, clear-in-shift of row1 col1, stray request in wait
        scroll_req_i = 1; tick(); scroll_req_i = 0;
        chk("scr_genmap", 32'(generate_map_o), 32'd1);
        chk("scr_busy", 32'(busy_o), 32'd1);
        scroll_req_i = 1;
        tick();
        scroll_req_i = 0;
        chk("scr_wait0_genmap", 32'(generate_map_o), 32'd0);
        chk("scr_wait0_valid", 32'(valid_rows_o), 32'd4);
        tick();
        chk("scr_wait1_genmap", 32'(generate_map_o), 32'd0);
        chk("scr_wait1_valid", 32'(valid_rows_o), 32'd4);
        layer_map_i = 7'b0101010; block_type_i = 7'b1000001; bonus_map_i = 7'b0000001;
        bonus_clr_i = 1; bonus_row_i = 3'd1; bonus_col_i = 3'd1;
        tick();
        bonus_clr_i = 0;
        layer_map_i = 7'b1111111; block_type_i = 7'b1111111; bonus_map_i = 7'b1111111;
        chk("scr_done_pulse", 32'(scroll_done_o), 32'd1);
        chk("scr_valid5", 32'(valid_rows_o), 32'd5);
        chk("scr_done_genmap", 32'(generate_map_o), 32'd0);
        tick();
        chk("scr_done_low", 32'(scroll_done_o), 32'd0);
        chk("scr_ready_busy", 32'(busy_o), 32'd0);
        chk("scr_no_second_req", 32'(generate_map_o), 32'd0);
        tick();
        chk("scr_no_second_shift", 32'(valid_rows_o), 32'd5);
        chk_row("scr", 0, 7'b0101010, 7'b1000001, 7'b0000001);
        chk_row("scr", 1, 7'b1010101, 7'b0001100, 7'b0000000);
        chk_row("scr", 2, 7'b0101010, 7'b0011000, 7'b0000000);
        chk_row("scr", 4, 7'b0001000, 7'b1100000, 7'b0000100);

        // Six more scrolls: valid_rows saturates at 8
        for (int i = 0; i < 6; i++) begin
            layer_map_i = 7'(i + 1); block_type_i = 7'b0; bonus_map_i = 7'b0;
            scroll_req_i = 1; tick(); scroll_req_i = 0;
            n = 0;
            while (scroll_done_o !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("scroll%0d_done_seen", i), 32'(scroll_done_o), 32'd1);
            tick();
            chk($sformatf("scroll%0d_valid", i), 32'(valid_rows_o), 32'((i + 6 > 8) ? 8 : i + 6));
            $display("scroll %0d valid_rows=%0d", i, valid_rows_o);
        end
        layer_map_i = '0;
        chk_row("sat", 0, 7'b0000110, 7'b0000000, 7'b0000000);
        chk_row("sat", 6, 7'b0101010, 7'b1000001, 7'b0000001);
        chk_row("sat", 7, 7'b1010101, 7'b0001100, 7'b0000000);

        // Restart from a full store
        start_i = 1; rd_row_i = 3'd7; tick(); start_i = 0;
        chk("restart_genmap", 32'(generate_map_o), 32'd1);
        chk("restart_valid", 32'(valid_rows_o), 32'd0);
        chk("restart_busy", 32'(busy_o), 32'd1);
        tick();
        chk("restart_cleared_r7", 32'(rd_layer_o), 32'd0);
        layer_map_i = 7'b1110000; load_layer_i = 1; tick();
        layer_map_i = 7'b0000111; map_ready_i = 1; tick();
        load_layer_i = 0; map_ready_i = 0; layer_map_i = '0;
        chk("refill_valid", 32'(valid_rows_o), 32'd2);
        chk("refill_busy", 32'(busy_o), 32'd0);
        chk_row("refill", 0, 7'b0000111, 7'b0000000, 7'b0000000);
        chk_row("refill", 1, 7'b1110000, 7'b0000000, 7'b0000000);
        chk_row("refill", 2, 7'b0000000, 7'b0000000, 7'b0000000);

        // Reset asserted in the scroll wait state
        layer_map_i = 7'b1011011;
        scroll_req_i = 1; tick(); scroll_req_i = 0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd1);
        chk("arst_valid", 32'(valid_rows_o), 32'd0);
        chk("arst_genmap", 32'(generate_map_o), 32'd0);
        tick(); tick();
        chk("arst_no_done", 32'(scroll_done_o), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("arst_still_done0", 32'(scroll_done_o), 32'd0);
        chk_row("arst", 0, 7'b0000000, 7'b0000000, 7'b0000000);
        chk_row("arst", 1, 7'b0000000, 7'b0000000, 7'b0000000);
        chk("arst_idle_busy", 32'(busy_o), 32'd1);
        chk("arst_idle_valid", 32'(valid_rows_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
